// File: rtl/muldiv_ctrl.sv
`timescale 1ns/1ps
// muldiv_ctrl: iterative MULT/MULTU/DIV/DIVU sequencer over HI/LO for the EX stage.
// A shift-add multiplier and a restoring divider share one 2*W product register
// and complete in W CALC cycles plus one FIX cycle.
// Ports:
//   clk, rst_n          clock, async active-low reset
//   start, op, a, b     operation request (sampled only in IDLE)
//   flush               abort of an in-flight operation
//   hi_we, lo_we, wdata MTHI/MTLO writes (IDLE only)
//   busy, stall, done   pipeline handshake (stall is combinational)
//   hi, lo              architectural HI/LO registers
module muldiv_ctrl #(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [1:0]            op,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    input  logic                  flush,
    input  logic                  hi_we,
    input  logic                  lo_we,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic                  busy,
    output logic                  stall,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] hi,
    output logic [DATA_WIDTH-1:0] lo
);

    localparam int unsigned W  = DATA_WIDTH;
    localparam int unsigned XW = DATA_WIDTH + 1;
    localparam int unsigned PW = 2 * DATA_WIDTH;
    localparam int unsigned CW = $clog2(DATA_WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [1:0]      op_q, op_d;
    logic [W-1:0]    opnd_q, opnd_d;   // multiplicand (mul) or divisor (div) magnitude
    logic [PW-1:0]   prod_q, prod_d;   // product; low half is dividend/quotient for div
    logic [W-1:0]    rem_q, rem_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            sa_q, sa_d;
    logic            sb_q, sb_d;
    logic            dz_q, dz_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic [W-1:0]    hi_q, hi_d;
    logic [W-1:0]    lo_q, lo_d;

    // Magnitude of the sign- or zero-extended operand; W bits always suffice.
    function automatic logic [W-1:0] mag(input logic [W-1:0] x, input logic sgn);
        logic [XW-1:0] ext;
        ext = {sgn & x[W-1], x};
        if (ext[XW-1]) begin
            ext = (~ext) + XW'(1);
        end
        return ext[W-1:0];
    endfunction

    logic          req_signed;
    logic [W-1:0]  a_mag;
    logic [W-1:0]  b_mag;
    assign req_signed = ~op[0];
    assign a_mag      = mag(a, req_signed);
    assign b_mag      = mag(b, req_signed);

    // One shift-add step: conditionally add, then shift right with the carry.
    logic [XW-1:0] mul_sum;
    assign mul_sum = {1'b0, prod_q[PW-1:W]} + (prod_q[0] ? {1'b0, opnd_q} : XW'(0));

    // One restoring-division step on a W+1 bit working remainder.
    logic [XW-1:0] rem_shift;
    logic          div_ge;
    logic [W-1:0]  rem_next;
    assign rem_shift = {rem_q, prod_q[W-1]};
    assign div_ge    = (rem_shift >= {1'b0, opnd_q});
    assign rem_next  = div_ge ? W'(rem_shift - {1'b0, opnd_q}) : rem_shift[W-1:0];

    // Sign correction for the FIX cycle.
    logic          res_signed;
    logic [PW-1:0] prod_neg;
    logic [W-1:0]  quo_neg;
    logic [W-1:0]  rem_neg;
    assign res_signed = ~op_q[0];
    assign prod_neg   = (~prod_q) + PW'(1);
    assign quo_neg    = (~prod_q[W-1:0]) + W'(1);
    assign rem_neg    = (~rem_q) + W'(1);

    // Next-state and datapath control.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        opnd_d  = opnd_q;
        prod_d  = prod_q;
        rem_d   = rem_q;
        cnt_d   = cnt_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        dz_d    = dz_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        hi_d    = hi_q;
        lo_d    = lo_q;

        unique case (state_q)
            S_IDLE: begin
                if (hi_we) hi_d = wdata;
                if (lo_we) lo_d = wdata;
                if (start && !flush) begin
                    op_d    = op;
                    opnd_d  = op[1] ? b_mag : a_mag;
                    prod_d  = {W'(0), (op[1] ? a_mag : b_mag)};
                    rem_d   = '0;
                    sa_d    = req_signed & a[W-1];
                    sb_d    = req_signed & b[W-1];
                    dz_d    = op[1] & (b == '0);
                    cnt_d   = CW'(W);
                    busy_d  = 1'b1;
                    state_d = S_CALC;
                end
            end

            S_CALC: begin
                if (flush) begin
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end else begin
                    if (op_q[1]) begin
                        rem_d          = rem_next;
                        prod_d[W-1:0]  = {prod_q[W-2:0], div_ge};
                    end else begin
                        prod_d = {mul_sum, prod_q[W-1:1]};
                    end
                    cnt_d = cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        state_d = S_FIX;
                    end
                end
            end

            S_FIX: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
                if (!flush) begin
                    done_d = 1'b1;
                    if (op_q[1]) begin
                        // Divide by zero leaves the all-ones quotient unsigned.
                        if (dz_q)
                            lo_d = '1;
                        else if (res_signed && (sa_q ^ sb_q))
                            lo_d = quo_neg;
                        else
                            lo_d = prod_q[W-1:0];
                        hi_d = (res_signed && sa_q) ? rem_neg : rem_q;
                    end else begin
                        if (res_signed && (sa_q ^ sb_q)) begin
                            hi_d = prod_neg[PW-1:W];
                            lo_d = prod_neg[W-1:0];
                        end else begin
                            hi_d = prod_q[PW-1:W];
                            lo_d = prod_q[W-1:0];
                        end
                    end
                end
            end

            default: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            op_q    <= '0;
            opnd_q  <= '0;
            prod_q  <= '0;
            rem_q   <= '0;
            cnt_q   <= '0;
            sa_q    <= 1'b0;
            sb_q    <= 1'b0;
            dz_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            opnd_q  <= opnd_d;
            prod_q  <= prod_d;
            rem_q   <= rem_d;
            cnt_q   <= cnt_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            dz_q    <= dz_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign busy  = busy_q;
    assign done  = done_q;
    assign hi    = hi_q;
    assign lo    = lo_q;
    assign stall = busy_q | (start & (state_q == S_IDLE) & ~flush);

endmodule

// File: doc/muldiv_ctrl.md
# muldiv_ctrl

Iterative multiply/divide controller for the EX stage of the 5-stage pipeline. It sequences a shared shift-add multiplier and restoring divider over HI/LO for MULT, MULTU, DIV and DIVU. Signed operands are sign-extended to DATA_WIDTH+1 bits and converted to magnitudes. It holds the pipeline with a stall output until the result is committed.

## Interface
Parameters:
- DATA_WIDTH, 32, operand and HI/LO width; must be ≥ 2.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  request a new operation; sampled only in IDLE
- op  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU; sampled with start
- a  in  DATA_WIDTH  multiplicand / dividend (rs)
- b  in  DATA_WIDTH  multiplier / divisor (rt)
- flush  in  1  synchronous abort of an in-flight operation
- hi_we  in  1  MTHI write; honoured only in IDLE
- lo_we  in  1  MTLO write; honoured only in IDLE
- wdata  in  DATA_WIDTH  MTHI/MTLO data
- busy  out  1  registered; high in CALC and FIX
- stall  out  1  combinational: busy | (start & state==IDLE & ~flush)
- done  out  1  registered one-cycle pulse when HI/LO commit
- hi  out  DATA_WIDTH  HI register
- lo  out  DATA_WIDTH  LO register

## Operation
- States: IDLE, CALC, FIX. Reset: IDLE, busy=0, done=0, hi=0, lo=0, internal counter=0.
- IDLE, start=1, flush=0: latch op. Latch the magnitudes of a and b: signed ops take the absolute value of the (DATA_WIDTH+1)-bit sign-extension; unsigned ops take zero-extension. Latch sign flags. Load counter=DATA_WIDTH. Go to CALC.
- CALC: one iteration per cycle; counter decrements; at counter==1 go to FIX.
  - Multiply: shift-add over a 2·DATA_WIDTH-bit product register.
  - Divide: restoring, one quotient bit per cycle; remainder is DATA_WIDTH+1 bits.
- FIX: apply sign correction, write hi/lo, pulse done, return to IDLE.
  - Multiply: the product is negated when sign(a)^sign(b) for MULT. hi gets the upper half, lo the lower half.
  - Divide: lo gets the quotient, negated when sign(a)^sign(b) for DIV. hi gets the remainder, negated when sign(a) for DIV. This is C truncation semantics.
- Divide by zero (b==0, DIV or DIVU): same latency; lo=all ones, hi=a (unmodified input). No exception is raised.
- Signed overflow DIV of -2^(W-1) by -1: lo=-2^(W-1) (0x80000000 for W=32), hi=0. This is the natural wrap of the magnitude arithmetic.
- start while busy: ignored, with no queueing.
- flush in CALC or FIX: next state is IDLE, busy=0, no done pulse, hi/lo unchanged. flush in IDLE together with start: start is rejected.
- hi_we/lo_we in IDLE: the register takes wdata next edge. Simultaneous start is also accepted, and the later FIX result overwrites. When busy: the write is ignored.
- rst_n low at any time: immediate return to reset values, abandoning any operation.

## Timing
- start accepted at edge N → busy=1 from N+1. CALC covers edges N+1…N+DATA_WIDTH. FIX is the cycle after N+DATA_WIDTH. hi/lo/done update at edge N+DATA_WIDTH+1, when busy drops.
- Total: DATA_WIDTH+1 cycles of stall after the start cycle, plus the start cycle itself (stall is combinationally high there). For W=32 that is 34 stalled cycles.
- done is high for exactly one cycle, coincident with the new hi/lo values.
- The next start is accepted in the first cycle with busy=0, so back-to-back operations are allowed with no bubble beyond that.

## Test plan
- MULT a=0xFFFFFFFD (−3), b=5 → after 33 edges: hi=0xFFFFFFFF, lo=0xFFFFFFF1, one done pulse. MULTU of the same operands → hi=0x00000004, lo=0xFFFFFFF1.
- DIVU a=7, b=2 → lo=3, hi=1. DIV a=0xFFFFFFF9 (−7), b=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIV a=0x12345678, b=0 → lo=0xFFFFFFFF, hi=0x12345678, at the same latency. DIV a=0x80000000, b=0xFFFFFFFF → lo=0x80000000, hi=0.
- Preload hi=0xAAAA5555 via hi_we. Start MULT and assert flush at CALC cycle 10 → busy falls next edge, no done, hi still 0xAAAA5555. Start during busy and hi_we during busy are both ignored.
- Deassert rst_n mid-CALC → busy, done, hi, lo are 0 immediately. After release, a DIVU 100/7 completes normally: lo=14, hi=2.
- stall check: stall is high in the start cycle and stays high through FIX, 34 cycles total for W=32. A back-to-back second start on the first idle cycle is accepted.
